// File: rtl/multi_channel_load_store_ctrl.sv
// Multi-channel load/store controller: round-robin arbitration of core channels onto one
// DMA path, with a command header beat followed by exactly LEN write or read beats.

module mclsc_lane #(
  parameter int CH_W = 1,
  parameter int LANE = 0
) (
  input  logic [CH_W-1:0] owner,
  input  logic            busy,
  input  logic            in_wdata,
  input  logic            in_rdata,
  input  logic            in_done,
  input  logic            dma_write_ready,
  input  logic            dma_read_valid,
  output logic            grant,
  output logic            wr_ack,
  output logic            rd_valid,
  output logic            done
);
  logic sel;

  assign sel      = busy && (owner == CH_W'(LANE));
  assign grant    = sel;
  assign wr_ack   = sel && in_wdata && dma_write_ready;
  assign rd_valid = sel && in_rdata && dma_read_valid;
  assign done     = sel && in_done;
endmodule

module multi_channel_load_store_ctrl #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 128,
  parameter int HADDR_W = 40,
  parameter int LADDR_W = 12,
  parameter int LEN_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           core_req,
  input  logic [NUM_CH-1:0]           core_rwn,
  input  logic [NUM_CH*HADDR_W-1:0]   core_hostAddr,
  input  logic [NUM_CH*LADDR_W-1:0]   core_localAddr,
  input  logic [NUM_CH*LEN_W-1:0]     core_transferLength,
  input  logic [NUM_CH*DATA_W-1:0]    core_writeData,
  output logic [NUM_CH-1:0]           core_grant,
  output logic [NUM_CH-1:0]           core_wr_ack,
  output logic [NUM_CH-1:0]           core_rd_valid,
  output logic [DATA_W-1:0]           core_readData,
  output logic [NUM_CH-1:0]           core_done,
  output logic                        dma_req,
  input  logic                        dma_resp,
  output logic                        dma_write_valid,
  output logic [DATA_W-1:0]           dma_write_data,
  input  logic                        dma_write_ready,
  input  logic                        dma_read_valid,
  input  logic [DATA_W-1:0]           dma_read_data,
  output logic                        dma_read_ready
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HDR_W = 8 + LEN_W + HADDR_W + 4 + LADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_WDATA, S_RDATA, S_DONE} state_t;

  typedef struct packed {
    logic               rwn;
    logic [HADDR_W-1:0] haddr;
    logic [LADDR_W-1:0] laddr;
    logic [LEN_W-1:0]   len;
  } xfer_t;

  state_t            state, state_n;
  logic [CH_W-1:0]   rr_ptr, owner, arb_idx, cand;
  logic              arb_found;
  logic [LEN_W-1:0]  beat_cnt;
  logic              last_beat;
  xfer_t             xfer_q;
  logic [HDR_W-1:0]  hdr_word;

  logic [NUM_CH-1:0][HADDR_W-1:0] haddr_v;
  logic [NUM_CH-1:0][LADDR_W-1:0] laddr_v;
  logic [NUM_CH-1:0][LEN_W-1:0]   len_v;
  logic [NUM_CH-1:0][DATA_W-1:0]  wdata_v;

  assign haddr_v = core_hostAddr;
  assign laddr_v = core_localAddr;
  assign len_v   = core_transferLength;
  assign wdata_v = core_writeData;

  // First requester at or after rr_ptr, wrapping around the channel set.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!arb_found && core_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign hdr_word  = {(xfer_q.rwn ? 8'h01 : 8'h03), xfer_q.len, xfer_q.haddr, 4'b0000, xfer_q.laddr};
  assign last_beat = (beat_cnt == xfer_q.len - 1'b1);

  always_comb begin
    state_n         = state;
    dma_req         = 1'b0;
    dma_write_valid = 1'b0;
    dma_write_data  = '0;
    dma_read_ready  = 1'b0;
    case (state)
      S_IDLE:  if (arb_found) state_n = S_REQ;
      S_REQ: begin
        dma_req = 1'b1;
        if (dma_resp) state_n = S_HDR;
      end
      S_HDR: begin
        dma_write_valid = 1'b1;
        dma_write_data  = DATA_W'(hdr_word);
        if (dma_write_ready) begin
          if (xfer_q.len == '0) state_n = S_DONE;
          else if (xfer_q.rwn)  state_n = S_RDATA;
          else                  state_n = S_WDATA;
        end
      end
      S_WDATA: begin
        dma_write_valid = 1'b1;
        dma_write_data  = wdata_v[owner];
        if (dma_write_ready && last_beat) state_n = S_DONE;
      end
      S_RDATA: begin
        dma_read_ready = 1'b1;
        if (dma_read_valid && last_beat) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      xfer_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (arb_found) begin
          owner  <= arb_idx;
          xfer_q <= '{rwn: core_rwn[arb_idx], haddr: haddr_v[arb_idx],
                      laddr: laddr_v[arb_idx], len: len_v[arb_idx]};
        end
        S_WDATA: if (dma_write_ready) beat_cnt <= beat_cnt + 1'b1;
        S_RDATA: if (dma_read_valid)  beat_cnt <= beat_cnt + 1'b1;
        S_DONE: begin
          beat_cnt <= '0;
          rr_ptr   <= (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign core_readData = (state == S_RDATA) ? dma_read_data : '0;

  // Ownership is implied by state != IDLE, so grant drops as DONE returns to IDLE.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    mclsc_lane #(.CH_W(CH_W), .LANE(g)) u_lane (
      .owner           (owner),
      .busy            (state != S_IDLE),
      .in_wdata        (state == S_WDATA),
      .in_rdata        (state == S_RDATA),
      .in_done         (state == S_DONE),
      .dma_write_ready (dma_write_ready),
      .dma_read_valid  (dma_read_valid),
      .grant           (core_grant[g]),
      .wr_ack          (core_wr_ack[g]),
      .rd_valid        (core_rd_valid[g]),
      .done            (core_done[g])
    );
  end
endmodule

// File: tb/tb_multi_channel_load_store_ctrl.sv
// Directed bench for multi_channel_load_store_ctrl: store/load flows, round-robin,
// zero-length transfers, write back-pressure and mid-transfer reset.

module tb_multi_channel_load_store_ctrl;
  localparam int NCH = 2, DW = 128, HW = 40, LW = 12, NW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]    core_req, core_rwn;
  logic [NCH*HW-1:0] core_hostAddr;
  logic [NCH*LW-1:0] core_localAddr;
  logic [NCH*NW-1:0] core_transferLength;
  logic [NCH*DW-1:0] core_writeData;
  logic [NCH-1:0]    core_grant, core_wr_ack, core_rd_valid, core_done;
  logic [DW-1:0]     core_readData;
  logic              dma_req, dma_resp, dma_write_valid, dma_write_ready;
  logic              dma_read_valid, dma_read_ready;
  logic [DW-1:0]     dma_write_data, dma_read_data;

  int nvec = 0, nerr = 0;
  int cyc = 0;

  // monitor state
  int acks [NCH];
  int rdv  [NCH];
  int dones[NCH];
  int wvr = 0, hold_err = 0, rd_bad = 0, hdr_cyc = 0, done_cyc = 0;
  logic [DW-1:0] hdr_q, stall_data;
  logic in_xfer = 1'b0, stall = 1'b0;
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  int done_q[$];

  multi_channel_load_store_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .HADDR_W(HW), .LADDR_W(LW), .LEN_W(NW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_rwn(core_rwn), .core_hostAddr(core_hostAddr),
    .core_localAddr(core_localAddr), .core_transferLength(core_transferLength),
    .core_writeData(core_writeData), .core_grant(core_grant), .core_wr_ack(core_wr_ack),
    .core_rd_valid(core_rd_valid), .core_readData(core_readData), .core_done(core_done),
    .dma_req(dma_req), .dma_resp(dma_resp), .dma_write_valid(dma_write_valid),
    .dma_write_data(dma_write_data), .dma_write_ready(dma_write_ready),
    .dma_read_valid(dma_read_valid), .dma_read_data(dma_read_data), .dma_read_ready(dma_read_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int c = 0; c < NCH; c++) begin acks[c] = 0; rdv[c] = 0; dones[c] = 0; end

  // Sampled mid-cycle: what is on the wires now is what the next rising edge transfers.
  always @(negedge clk) begin
    if (rst) begin
      in_xfer <= 1'b0;
      stall   <= 1'b0;
    end else begin
      if (dma_write_valid && dma_write_ready) begin
        wvr <= wvr + 1;
        if (!in_xfer) begin
          hdr_q   <= dma_write_data;
          hdr_cyc <= cyc;
          in_xfer <= 1'b1;
        end else wq.push_back(dma_write_data);
      end
      if (stall && dma_write_data !== stall_data) hold_err <= hold_err + 1;
      stall      <= dma_write_valid && !dma_write_ready && in_xfer;
      stall_data <= dma_write_data;
      if (dma_read_ready && (dma_write_valid || core_grant == '0)) rd_bad <= rd_bad + 1;
      for (int c = 0; c < NCH; c++) begin
        if (core_wr_ack[c]) acks[c] <= acks[c] + 1;
        if (core_rd_valid[c]) begin
          rdv[c] <= rdv[c] + 1;
          rq.push_back(core_readData);
        end
        if (core_done[c]) begin
          dones[c] <= dones[c] + 1;
          done_q.push_back(c);
          done_cyc <= cyc;
          in_xfer  <= 1'b0;
        end
      end
    end
  end

  function automatic logic [DW-1:0] hdr_exp(input logic [7:0] op, input logic [NW-1:0] len,
                                            input logic [HW-1:0] ha, input logic [LW-1:0] la);
    logic [DW-1:0] h;
    h = '0;
    h[11:0]  = la;
    h[55:16] = ha;
    h[71:56] = len;
    h[79:72] = op;
    return h;
  endfunction

  function automatic logic [DW-1:0] wval(input int ch, input int j);
    logic [DW-1:0] v;
    v = '0;
    v[127:120] = 8'hA0 + ch[7:0];
    v[63:32]   = 32'hBEEF_0000;
    v[31:0]    = j;
    return v;
  endfunction

  function automatic logic [DW-1:0] rval(input int j);
    logic [DW-1:0] v;
    v = '0;
    v[127:96] = 32'hFEED_0000;
    v[31:0]   = j;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic rwn, input logic [HW-1:0] ha,
                        input logic [LW-1:0] la, input logic [NW-1:0] len);
    core_rwn[ch]                   = rwn;
    core_hostAddr[ch*HW +: HW]     = ha;
    core_localAddr[ch*LW +: LW]    = la;
    core_transferLength[ch*NW +: NW] = len;
  endtask

  task automatic drive_data();
    for (int c = 0; c < NCH; c++) core_writeData[c*DW +: DW] = wval(c, acks[c]);
    dma_read_data = rval(rdv[0] + rdv[1]);
  endtask

  // Run until the channel's done pulse, drop its request in the DONE cycle, then settle.
  task automatic run_xfer(input int ch, input int budget, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      drive_data();
      if (toggle) dma_write_ready = ~dma_write_ready;
      if (core_done[ch]) begin
        core_req[ch] = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      core_req[ch] = 1'b0;
      nvec++; nerr++;
      $display("FAIL xfer_timeout ch%0d: no core_done within %0d cycles", ch, budget);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    core_req = 2'b11;
    tick(); tick();
    nvec++; if (core_grant !== 2'b00) begin nerr++; $display("FAIL rst_grant got=%b exp=00", core_grant); end
    nvec++; if (dma_req !== 1'b0) begin nerr++; $display("FAIL rst_dma_req got=%b exp=0", dma_req); end
    nvec++; if (dma_write_valid !== 1'b0 || dma_write_data !== '0) begin nerr++;
      $display("FAIL rst_write got v=%b d=%h exp 0/0", dma_write_valid, dma_write_data); end
    nvec++; if (dma_read_ready !== 1'b0 || core_readData !== '0) begin nerr++;
      $display("FAIL rst_read got rdy=%b d=%h exp 0/0", dma_read_ready, core_readData); end
    nvec++; if ({core_done, core_wr_ack, core_rd_valid} !== 6'b0) begin nerr++;
      $display("FAIL rst_strobes got=%b exp=0", {core_done, core_wr_ack, core_rd_valid}); end
    core_req = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store();
    int w0, a0, v0, d0;
    bit ok;
    set_ch(0, 1'b0, 40'hAB_CDEF_0123, 12'h456, 16'd3);
    w0 = wq.size(); a0 = acks[0]; v0 = wvr; d0 = dones[0];
    dma_resp = 1'b0;
    dma_write_ready = 1'b1;
    core_req[0] = 1'b1;
    tick();
    nvec++; if (core_grant !== 2'b01) begin nerr++; $display("FAIL store_grant got=%b exp=01", core_grant); end
    nvec++; if (dma_req !== 1'b1) begin nerr++; $display("FAIL store_dma_req got=%b exp=1", dma_req); end
    tick();
    nvec++; if (dma_req !== 1'b1 || dma_write_valid !== 1'b0) begin nerr++;
      $display("FAIL store_req_hold got req=%b wv=%b exp 1/0", dma_req, dma_write_valid); end
    dma_resp = 1'b1;
    run_xfer(0, 20, 1'b0, ok);
    nvec++; if (hdr_q !== hdr_exp(8'h03, 16'd3, 40'hAB_CDEF_0123, 12'h456)) begin nerr++;
      $display("FAIL store_hdr got=%h exp=%h", hdr_q, hdr_exp(8'h03, 16'd3, 40'hAB_CDEF_0123, 12'h456)); end
    nvec++; if (acks[0] - a0 !== 3) begin nerr++; $display("FAIL store_acks got=%0d exp=3", acks[0] - a0); end
    nvec++; if (wvr - v0 !== 4) begin nerr++; $display("FAIL store_vr_cycles got=%0d exp=4", wvr - v0); end
    nvec++; if (dones[0] - d0 !== 1) begin nerr++; $display("FAIL store_done got=%0d exp=1", dones[0] - d0); end
    for (int j = 0; j < 3; j++) begin
      nvec++;
      if (wq.size() <= w0 + j) begin nerr++; $display("FAIL store_beat%0d missing", j); end
      else if (wq[w0+j] !== wval(0, j)) begin nerr++;
        $display("FAIL store_beat%0d got=%h exp=%h", j, wq[w0+j], wval(0, j)); end
    end
    nvec++; if (core_grant !== 2'b00 || dma_write_valid !== 1'b0) begin nerr++;
      $display("FAIL store_idle got grant=%b wv=%b exp 00/0", core_grant, dma_write_valid); end
  endtask

  task automatic test_load();
    int r0, rs, x0, v0, d1, rb0;
    bit ok;
    set_ch(1, 1'b1, 40'h12_3456_7890, 12'h0AB, 16'd2);
    r0 = rq.size(); rs = rdv[0] + rdv[1]; x0 = rdv[0]; v0 = wvr; d1 = dones[1]; rb0 = rd_bad;
    dma_read_valid = 1'b1;
    core_req[1] = 1'b1;
    tick();
    nvec++; if (core_grant !== 2'b10) begin nerr++; $display("FAIL load_grant got=%b exp=10", core_grant); end
    run_xfer(1, 20, 1'b0, ok);
    dma_read_valid = 1'b0;
    nvec++; if (hdr_q !== hdr_exp(8'h01, 16'd2, 40'h12_3456_7890, 12'h0AB)) begin nerr++;
      $display("FAIL load_hdr got=%h exp=%h", hdr_q, hdr_exp(8'h01, 16'd2, 40'h12_3456_7890, 12'h0AB)); end
    nvec++; if (rdv[1] - (rs - x0) !== 2 || rdv[0] !== x0) begin nerr++;
      $display("FAIL load_rd_valid got ch1=%0d ch0=%0d exp 2/0", rdv[1] - (rs - x0), rdv[0] - x0); end
    for (int j = 0; j < 2; j++) begin
      nvec++;
      if (rq.size() <= r0 + j) begin nerr++; $display("FAIL load_beat%0d missing", j); end
      else if (rq[r0+j] !== rval(rs + j)) begin nerr++;
        $display("FAIL load_beat%0d got=%h exp=%h", j, rq[r0+j], rval(rs + j)); end
    end
    nvec++; if (wvr - v0 !== 1) begin nerr++; $display("FAIL load_write_beats got=%0d exp=1", wvr - v0); end
    nvec++; if (dones[1] - d1 !== 1) begin nerr++; $display("FAIL load_done got=%0d exp=1", dones[1] - d1); end
    nvec++; if (rd_bad - rb0 !== 0) begin nerr++; $display("FAIL load_ready_outside got=%0d exp=0", rd_bad - rb0); end
  endtask

  task automatic test_back_to_back();
    int q0;
    bit ok;
    set_ch(0, 1'b0, 40'h00_0000_1000, 12'h010, 16'd1);
    set_ch(1, 1'b1, 40'h00_0000_2000, 12'h020, 16'd1);
    q0 = done_q.size();
    dma_read_valid = 1'b1;
    core_req = 2'b11;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      drive_data();
      if (core_done != '0 && done_q.size() - q0 >= 2) begin
        core_req = 2'b00;
        ok = 1'b1;
        break;
      end
    end
    core_req = 2'b00;
    tick();
    dma_read_valid = 1'b0;
    nvec++; if (!ok || done_q.size() - q0 !== 3) begin nerr++;
      $display("FAIL rr_count got=%0d exp=3", done_q.size() - q0); end
    else begin
      nvec++; if (done_q[q0] !== 0) begin nerr++; $display("FAIL rr_first got=%0d exp=0", done_q[q0]); end
      nvec++; if (done_q[q0+1] !== 1) begin nerr++; $display("FAIL rr_second got=%0d exp=1", done_q[q0+1]); end
      nvec++; if (done_q[q0+2] !== 0) begin nerr++; $display("FAIL rr_third got=%0d exp=0", done_q[q0+2]); end
    end
    tick(); tick();
    nvec++; if (core_grant !== 2'b00) begin nerr++; $display("FAIL rr_idle got=%b exp=00", core_grant); end
  endtask

  task automatic test_len_zero();
    int a0, v0, r0;
    bit ok;
    set_ch(0, 1'b0, 40'h55_0000_0000, 12'hFFF, 16'd0);
    a0 = acks[0]; v0 = wvr;
    core_req[0] = 1'b1;
    run_xfer(0, 20, 1'b0, ok);
    nvec++; if (done_cyc - hdr_cyc !== 1) begin nerr++;
      $display("FAIL len0_store_done_lag got=%0d exp=1", done_cyc - hdr_cyc); end
    nvec++; if (acks[0] - a0 !== 0 || wvr - v0 !== 1) begin nerr++;
      $display("FAIL len0_store_beats got acks=%0d vr=%0d exp 0/1", acks[0] - a0, wvr - v0); end
    nvec++; if (hdr_q !== hdr_exp(8'h03, 16'd0, 40'h55_0000_0000, 12'hFFF)) begin nerr++;
      $display("FAIL len0_store_hdr got=%h", hdr_q); end
    set_ch(1, 1'b1, 40'h66_0000_0000, 12'h001, 16'd0);
    r0 = rdv[1];
    dma_read_valid = 1'b1;
    core_req[1] = 1'b1;
    run_xfer(1, 20, 1'b0, ok);
    dma_read_valid = 1'b0;
    nvec++; if (done_cyc - hdr_cyc !== 1) begin nerr++;
      $display("FAIL len0_load_done_lag got=%0d exp=1", done_cyc - hdr_cyc); end
    nvec++; if (rdv[1] - r0 !== 0) begin nerr++; $display("FAIL len0_load_beats got=%0d exp=0", rdv[1] - r0); end
  endtask

  task automatic test_backpressure();
    int w0, a0, v0, h0, rb0;
    bit ok;
    set_ch(0, 1'b0, 40'h77_8899_AABB, 12'h321, 16'd4);
    w0 = wq.size(); a0 = acks[0]; v0 = wvr; h0 = hold_err; rb0 = rd_bad;
    dma_read_valid = 1'b1;
    core_req[0] = 1'b1;
    run_xfer(0, 40, 1'b1, ok);
    dma_write_ready = 1'b1;
    dma_read_valid = 1'b0;
    nvec++; if (acks[0] - a0 !== 4) begin nerr++; $display("FAIL bp_acks got=%0d exp=4", acks[0] - a0); end
    nvec++; if (wvr - v0 !== 5) begin nerr++; $display("FAIL bp_vr_cycles got=%0d exp=5", wvr - v0); end
    nvec++; if (hold_err - h0 !== 0) begin nerr++; $display("FAIL bp_data_hold got=%0d exp=0", hold_err - h0); end
    nvec++; if (rd_bad - rb0 !== 0) begin nerr++; $display("FAIL bp_read_ready got=%0d exp=0", rd_bad - rb0); end
    for (int j = 0; j < 4; j++) begin
      nvec++;
      if (wq.size() <= w0 + j) begin nerr++; $display("FAIL bp_beat%0d missing", j); end
      else if (wq[w0+j] !== wval(0, a0 + j)) begin nerr++;
        $display("FAIL bp_beat%0d got=%h exp=%h", j, wq[w0+j], wval(0, a0 + j)); end
    end
  endtask

  task automatic test_reset_mid();
    int a0, d0;
    bit ok;
    set_ch(0, 1'b0, 40'h01_0203_0405, 12'h0C0, 16'd5);
    a0 = acks[0]; d0 = dones[0];
    core_req[0] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      drive_data();
      if (acks[0] - a0 >= 2) begin ok = 1'b1; break; end
    end
    nvec++; if (!ok) begin nerr++; $display("FAIL rstmid_reach got acks=%0d exp=2", acks[0] - a0); end
    rst = 1'b1;
    #1;
    nvec++; if (core_grant !== 2'b00 || dma_write_valid !== 1'b0 || dma_write_data !== '0 || core_wr_ack !== 2'b00) begin
      nerr++; $display("FAIL rstmid_outputs got g=%b wv=%b d=%h ack=%b exp 0", core_grant, dma_write_valid, dma_write_data, core_wr_ack); end
    core_req[0] = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    nvec++; if (dones[0] - d0 !== 0 || core_grant !== 2'b00) begin nerr++;
      $display("FAIL rstmid_no_done got done=%0d grant=%b exp 0/00", dones[0] - d0, core_grant); end
    set_ch(0, 1'b0, 40'h01_0203_0405, 12'h0C0, 16'd2);
    a0 = acks[0]; d0 = dones[0];
    core_req[0] = 1'b1;
    run_xfer(0, 20, 1'b0, ok);
    nvec++; if (hdr_q !== hdr_exp(8'h03, 16'd2, 40'h01_0203_0405, 12'h0C0)) begin nerr++;
      $display("FAIL rstmid_fresh_hdr got=%h", hdr_q); end
    nvec++; if (acks[0] - a0 !== 2 || dones[0] - d0 !== 1) begin nerr++;
      $display("FAIL rstmid_fresh got acks=%0d done=%0d exp 2/1", acks[0] - a0, dones[0] - d0); end
  endtask

  initial begin
    rst = 1'b1;
    core_req = '0; core_rwn = '0; core_hostAddr = '0; core_localAddr = '0;
    core_transferLength = '0; core_writeData = '0;
    dma_resp = 1'b1; dma_write_ready = 1'b1; dma_read_valid = 1'b0; dma_read_data = '0;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
